ace_snoop_collector: RTL and testbench

// Broadcasts one AC snoop request from the CCU to a masked subset of NoSnoopPorts cached masters.

---
 rtl/ace_snoop_collector.sv | 236 +++++++++++++++++++++++
 tb/tb_ace_snoop_collector.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_collector.sv
// ACE snoop collector: sends one AC request to a masked set of cached masters, merges their CR
// responses and forwards one cacheline of CD data from the lowest-index data source.
module ace_snoop_collector #(
    parameter int unsigned NoSnoopPorts   = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned CachelineBeats = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    // request from the CCU
    input  logic                              ac_valid_i,
    output logic                              ac_ready_o,
    input  logic [AddrWidth-1:0]              ac_addr_i,
    input  logic [3:0]                        ac_snoop_i,
    input  logic [2:0]                        ac_prot_i,
    input  logic [NoSnoopPorts-1:0]           ac_mask_i,
    // per-port snoop channels
    output logic [NoSnoopPorts-1:0]           ac_valid_o,
    input  logic [NoSnoopPorts-1:0]           ac_ready_i,
    output logic [AddrWidth-1:0]              ac_addr_o,
    output logic [3:0]                        ac_snoop_o,
    output logic [2:0]                        ac_prot_o,
    input  logic [NoSnoopPorts-1:0]           cr_valid_i,
    output logic [NoSnoopPorts-1:0]           cr_ready_o,
    input  logic [NoSnoopPorts*5-1:0]         cr_resp_i,
    input  logic [NoSnoopPorts-1:0]           cd_valid_i,
    output logic [NoSnoopPorts-1:0]           cd_ready_o,
    input  logic [NoSnoopPorts*DataWidth-1:0] cd_data_i,
    input  logic [NoSnoopPorts-1:0]           cd_last_i,
    // merged response and data to the CCU
    output logic                              cr_valid_o,
    input  logic                              cr_ready_i,
    output logic [4:0]                        cr_resp_o,
    output logic                              cd_valid_o,
    input  logic                              cd_ready_i,
    output logic [DataWidth-1:0]              cd_data_o,
    output logic                              cd_last_o,
    output logic                              busy_o,
    output logic                              proto_err_o
);

    localparam int unsigned CntWidth = (CachelineBeats > 1) ? $clog2(CachelineBeats) : 1;
    localparam int unsigned SelWidth = (NoSnoopPorts > 1) ? $clog2(NoSnoopPorts) : 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(CachelineBeats - 1);

    typedef enum logic [1:0] {StIdle, StSnoop, StResp, StData} state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [3:0]              snoop_q, snoop_d;
    logic [2:0]              prot_q, prot_d;
    logic [NoSnoopPorts-1:0] ac_pend_q, ac_pend_d;
    logic [NoSnoopPorts-1:0] cr_pend_q, cr_pend_d;
    logic [NoSnoopPorts-1:0] dt_mask_q, dt_mask_d;
    logic [NoSnoopPorts-1:0] done_q, done_d;
    logic [4:0]              resp_q, resp_d;
    logic [SelWidth-1:0]     sel_q, sel_d;
    logic [CntWidth-1:0]     cnt_q [NoSnoopPorts];
    logic [CntWidth-1:0]     cnt_d [NoSnoopPorts];
    logic                    proto_err_q, proto_err_d;

    logic [NoSnoopPorts-1:0] cr_hs;
    logic [NoSnoopPorts-1:0] cd_hs;
    logic [SelWidth-1:0]     sel_lowest;
    logic                    sel_found;

    // Lowest-index port that announced a data transfer
    always_comb begin
        sel_lowest = '0;
        sel_found  = 1'b0;
        for (int i = 0; i < int'(NoSnoopPorts); i++) begin
            if (dt_mask_q[i] && !sel_found) begin
                sel_lowest = SelWidth'(i);
                sel_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        prot_d      = prot_q;
        ac_pend_d   = ac_pend_q;
        cr_pend_d   = cr_pend_q;
        dt_mask_d   = dt_mask_q;
        done_d      = done_q;
        resp_d      = resp_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;

        ac_ready_o  = 1'b0;
        ac_valid_o  = '0;
        cr_ready_o  = '0;
        cd_ready_o  = '0;
        cr_valid_o  = 1'b0;
        cr_resp_o   = '0;
        cd_valid_o  = 1'b0;
        cd_data_o   = '0;
        cd_last_o   = 1'b0;
        cr_hs       = '0;
        cd_hs       = '0;

        unique case (state_q)
            StIdle: begin
                ac_ready_o = rst_ni;
                if (ac_valid_i && rst_ni) begin
                    addr_d    = ac_addr_i;
                    snoop_d   = ac_snoop_i;
                    prot_d    = ac_prot_i;
                    resp_d    = '0;
                    dt_mask_d = '0;
                    sel_d     = '0;
                    if (ac_mask_i != '0) begin
                        ac_pend_d = ac_mask_i;
                        cr_pend_d = ac_mask_i;
                        state_d   = StSnoop;
                    end else begin
                        state_d = StResp;
                    end
                end
            end

            StSnoop: begin
                ac_valid_o = ac_pend_q;
                ac_pend_d  = ac_pend_q & ~ac_ready_i;
                // A port's CR is only taken once its AC has been handshaked
                cr_ready_o = cr_pend_q & ~ac_pend_q;
                cr_hs      = cr_valid_i & cr_ready_o;
                cr_pend_d  = cr_pend_q & ~cr_hs;
                for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                    if (cr_hs[i]) begin
                        resp_d = resp_d | cr_resp_i[i*5 +: 5];
                        if (cr_resp_i[i*5]) begin
                            dt_mask_d[i] = 1'b1;
                        end
                    end
                end
                if (ac_pend_q == '0 && cr_pend_q == '0) begin
                    sel_d   = sel_lowest;
                    state_d = StResp;
                end
            end

            StResp: begin
                cr_valid_o = 1'b1;
                cr_resp_o  = resp_q;
                if (cr_ready_i) begin
                    if (dt_mask_q != '0) begin
                        done_d = '0;
                        for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                            cnt_d[i] = '0;
                        end
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StData: begin
                cd_valid_o = cd_valid_i[sel_q] & ~done_q[sel_q];
                cd_data_o  = cd_data_i[int'(sel_q)*DataWidth +: DataWidth];
                cd_last_o  = (cnt_q[sel_q] == LastBeat) & ~done_q[sel_q];
                for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                    if (dt_mask_q[i] && !done_q[i]) begin
                        // Non-selected data sources are drained unconditionally
                        cd_ready_o[i] = (SelWidth'(i) == sel_q) ? cd_ready_i : 1'b1;
                    end
                end
                cd_hs = cd_valid_i & cd_ready_o;
                for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                    if (cd_hs[i]) begin
                        if (cd_last_i[i] != (cnt_q[i] == LastBeat)) begin
                            proto_err_d = 1'b1;
                        end
                        if (cnt_q[i] == LastBeat) begin
                            cnt_d[i]  = '0;
                            done_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                if ((done_d & dt_mask_q) == dt_mask_q) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            snoop_q     <= '0;
            prot_q      <= '0;
            ac_pend_q   <= '0;
            cr_pend_q   <= '0;
            dt_mask_q   <= '0;
            done_q      <= '0;
            resp_q      <= '0;
            sel_q       <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snoop_q     <= snoop_d;
            prot_q      <= prot_d;
            ac_pend_q   <= ac_pend_d;
            cr_pend_q   <= cr_pend_d;
            dt_mask_q   <= dt_mask_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            sel_q       <= sel_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < int'(NoSnoopPorts); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ac_addr_o   = addr_q;
    assign ac_snoop_o  = snoop_q;
    assign ac_prot_o   = prot_q;
    assign busy_o      = (state_q != StIdle);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Directed self-checking bench for ace_snoop_collector with default parameters
// (4 ports, 64-bit address/data, 4 beats per line).
module tb_ace_snoop_collector;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ac_valid_i;
    logic            ac_ready_o;
    logic [AW-1:0]   ac_addr_i;
    logic [3:0]      ac_snoop_i;
    logic [2:0]      ac_prot_i;
    logic [N-1:0]    ac_mask_i;
    logic [N-1:0]    ac_valid_o;
    logic [N-1:0]    ac_ready_i;
    logic [AW-1:0]   ac_addr_o;
    logic [3:0]      ac_snoop_o;
    logic [2:0]      ac_prot_o;
    logic [N-1:0]    cr_valid_i;
    logic [N-1:0]    cr_ready_o;
    logic [N*5-1:0]  cr_resp_i;
    logic [N-1:0]    cd_valid_i;
    logic [N-1:0]    cd_ready_o;
    logic [N*DW-1:0] cd_data_i;
    logic [N-1:0]    cd_last_i;
    logic            cr_valid_o;
    logic            cr_ready_i;
    logic [4:0]      cr_resp_o;
    logic            cd_valid_o;
    logic            cd_ready_i;
    logic [DW-1:0]   cd_data_o;
    logic            cd_last_o;
    logic            busy_o;
    logic            proto_err_o;

    int n_cmp = 0;
    int n_err = 0;

    ace_snoop_collector dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ac_valid_i  (ac_valid_i),
        .ac_ready_o  (ac_ready_o),
        .ac_addr_i   (ac_addr_i),
        .ac_snoop_i  (ac_snoop_i),
        .ac_prot_i   (ac_prot_i),
        .ac_mask_i   (ac_mask_i),
        .ac_valid_o  (ac_valid_o),
        .ac_ready_i  (ac_ready_i),
        .ac_addr_o   (ac_addr_o),
        .ac_snoop_o  (ac_snoop_o),
        .ac_prot_o   (ac_prot_o),
        .cr_valid_i  (cr_valid_i),
        .cr_ready_o  (cr_ready_o),
        .cr_resp_i   (cr_resp_i),
        .cd_valid_i  (cd_valid_i),
        .cd_ready_o  (cd_ready_o),
        .cd_data_i   (cd_data_i),
        .cd_last_i   (cd_last_i),
        .cr_valid_o  (cr_valid_o),
        .cr_ready_i  (cr_ready_i),
        .cr_resp_o   (cr_resp_o),
        .cd_valid_o  (cd_valid_o),
        .cd_ready_i  (cd_ready_i),
        .cd_data_o   (cd_data_o),
        .cd_last_o   (cd_last_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one request in IDLE; returns one step past the accepting edge
    task automatic issue(input logic [N-1:0] mask, input logic [AW-1:0] addr);
        ac_valid_i = 1'b1;
        ac_mask_i  = mask;
        ac_addr_i  = addr;
        ac_snoop_i = 4'h7;
        ac_prot_i  = 3'h2;
        #1;
        check("ac_ready_idle", 64'(ac_ready_o), 64'd1);
        cyc();
        ac_valid_i = 1'b0;
        ac_mask_i  = '0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        ac_valid_i = 1'b0;
        ac_addr_i  = '0;
        ac_snoop_i = '0;
        ac_prot_i  = '0;
        ac_mask_i  = '0;
        ac_ready_i = '0;
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cd_valid_i = '0;
        cd_data_i  = '0;
        cd_last_i  = '0;
        cr_ready_i = 1'b0;
        cd_ready_i = 1'b0;
        cyc();
        cyc();
        check("rst_ac_ready", 64'(ac_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_cr_valid", 64'(cr_valid_o), 64'd0);
        check("rst_perr", 64'(proto_err_o), 64'd0);
        rst_ni = 1'b1;
        cyc();
        check("idle_ac_ready", 64'(ac_ready_o), 64'd1);

        // Mask 0110, both ports ready, null responses
        issue(4'b0110, 64'h1234_5678_9ABC_DEF0);
        check("t1_ac_valid", 64'(ac_valid_o), 64'b0110);
        check("t1_addr", ac_addr_o, 64'h1234_5678_9ABC_DEF0);
        check("t1_snoop", 64'(ac_snoop_o), 64'h7);
        check("t1_prot", 64'(ac_prot_o), 64'h2);
        check("t1_busy", 64'(busy_o), 64'd1);
        check("t1_ac_ready_busy", 64'(ac_ready_o), 64'd0);
        check("t1_cr_ready_early", 64'(cr_ready_o), 64'd0);
        ac_ready_i = 4'b1111;
        cyc();
        check("t1_ac_valid_done", 64'(ac_valid_o), 64'd0);
        cr_valid_i = 4'b0110;
        cr_resp_i  = '0;
        #1;
        check("t1_cr_ready", 64'(cr_ready_o), 64'b0110);
        cyc();
        cr_valid_i = '0;
        check("t1_no_resp_yet", 64'(cr_valid_o), 64'd0);
        cyc();
        check("t1_cr_valid", 64'(cr_valid_o), 64'd1);
        check("t1_cr_resp", 64'(cr_resp_o), 64'd0);
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        check("t1_busy_fall", 64'(busy_o), 64'd0);
        check("t1_cd_valid", 64'(cd_valid_o), 64'd0);
        check("t1_idle_ready", 64'(ac_ready_o), 64'd1);

        // Mask 1111; ports 2 and 3 transfer data, port 2 is forwarded
        issue(4'b1111, 64'hCAFE_0000);
        check("t2_ac_valid", 64'(ac_valid_o), 64'b1111);
        cyc();
        cr_valid_i = 4'b1111;
        cr_resp_i  = {5'b01001, 5'b00101, 5'b00000, 5'b00000};
        #1;
        check("t2_cr_ready", 64'(cr_ready_o), 64'b1111);
        cyc();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cyc();
        // Early CD is held off outside the data phase
        cd_valid_i = 4'b1100;
        #1;
        check("t2_cr_valid", 64'(cr_valid_o), 64'd1);
        check("t2_cr_resp", 64'(cr_resp_o), 64'b01101);
        check("t2_cd_backpressure", 64'(cd_ready_o), 64'd0);
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        cd_ready_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cd_data_i = '0;
            cd_data_i[2*DW +: DW] = 64'hA0 + 64'(b);
            cd_data_i[3*DW +: DW] = 64'hB0 + 64'(b);
            cd_last_i = (b == 3) ? 4'b1100 : 4'b0000;
            #1;
            check("t2_cd_valid", 64'(cd_valid_o), 64'd1);
            check("t2_cd_data", cd_data_o, 64'hA0 + 64'(b));
            check("t2_cd_last", 64'(cd_last_o), (b == 3) ? 64'd1 : 64'd0);
            check("t2_cd_ready", 64'(cd_ready_o), 64'b1100);
            cyc();
        end
        cd_valid_i = '0;
        cd_last_i  = '0;
        cd_ready_i = 1'b0;
        check("t2_busy_fall", 64'(busy_o), 64'd0);
        check("t2_perr", 64'(proto_err_o), 64'd0);

        // Empty mask goes straight to the response
        issue(4'b0000, 64'h40);
        check("t3_ac_valid", 64'(ac_valid_o), 64'd0);
        check("t3_cr_valid", 64'(cr_valid_o), 64'd1);
        check("t3_cr_resp", 64'(cr_resp_o), 64'd0);
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        check("t3_busy_fall", 64'(busy_o), 64'd0);

        // Port 1 stalls AC for 10 cycles while already offering CR
        ac_ready_i = '0;
        issue(4'b0010, 64'h80);
        cr_valid_i = 4'b0010;
        cr_resp_i  = {5'b0, 5'b0, 5'b00100, 5'b0};
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t4_cr_ready_held", 64'(cr_ready_o), 64'd0);
            check("t4_ac_valid", 64'(ac_valid_o), 64'b0010);
            check("t4_no_resp", 64'(cr_valid_o), 64'd0);
            cyc();
        end
        ac_ready_i = 4'b0010;
        cyc();
        ac_ready_i = '0;
        #1;
        check("t4_cr_ready", 64'(cr_ready_o), 64'b0010);
        cyc();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cyc();
        check("t4_cr_valid", 64'(cr_valid_o), 64'd1);
        check("t4_cr_resp", 64'(cr_resp_o), 64'b00100);
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        check("t4_busy_fall", 64'(busy_o), 64'd0);

        // Early cd_last on beat 1 flags a protocol error but the line completes
        ac_ready_i = 4'b1111;
        issue(4'b0001, 64'hC0);
        cyc();
        cr_valid_i = 4'b0001;
        cr_resp_i  = {5'b0, 5'b0, 5'b0, 5'b00001};
        cyc();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cyc();
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        cd_ready_i = 1'b1;
        cd_valid_i = 4'b0001;
        for (int b = 0; b < 4; b++) begin
            cd_data_i = '0;
            cd_data_i[0 +: DW] = 64'hD0 + 64'(b);
            cd_last_i = (b == 1) ? 4'b0001 : 4'b0000;
            #1;
            check("t5_cd_last", 64'(cd_last_o), (b == 3) ? 64'd1 : 64'd0);
            check("t5_busy", 64'(busy_o), 64'd1);
            cyc();
            if (b == 1) check("t5_perr_set", 64'(proto_err_o), 64'd1);
        end
        cd_valid_i = '0;
        cd_last_i  = '0;
        cd_ready_i = 1'b0;
        check("t5_busy_fall", 64'(busy_o), 64'd0);
        check("t5_perr_sticky", 64'(proto_err_o), 64'd1);

        // Reset in the middle of a data phase
        issue(4'b0011, 64'h100);
        cyc();
        cr_valid_i = 4'b0011;
        cr_resp_i  = {5'b0, 5'b0, 5'b00001, 5'b00001};
        cyc();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cyc();
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        cd_ready_i = 1'b1;
        cd_valid_i = 4'b0011;
        cd_data_i  = '0;
        cyc();
        check("t6_mid_data_busy", 64'(busy_o), 64'd1);
        check("t6_perr_before", 64'(proto_err_o), 64'd1);
        rst_ni = 1'b0;
        cyc();
        check("t6_ac_valid", 64'(ac_valid_o), 64'd0);
        check("t6_ac_ready", 64'(ac_ready_o), 64'd0);
        check("t6_cr_ready", 64'(cr_ready_o), 64'd0);
        check("t6_cd_ready", 64'(cd_ready_o), 64'd0);
        check("t6_cd_valid", 64'(cd_valid_o), 64'd0);
        check("t6_cr_valid", 64'(cr_valid_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_perr_clr", 64'(proto_err_o), 64'd0);
        rst_ni     = 1'b1;
        cd_valid_i = '0;
        cd_ready_i = 1'b0;
        cyc();

        // A normal snoop after the reset
        issue(4'b0100, 64'h140);
        check("t6b_ac_valid", 64'(ac_valid_o), 64'b0100);
        cyc();
        cr_valid_i = 4'b0100;
        cr_resp_i  = {5'b0, 5'b01000, 5'b0, 5'b0};
        cyc();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cyc();
        check("t6b_cr_valid", 64'(cr_valid_o), 64'd1);
        check("t6b_cr_resp", 64'(cr_resp_o), 64'b01000);
        cr_ready_i = 1'b1;
        cyc();
        cr_ready_i = 1'b0;
        check("t6b_busy_fall", 64'(busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
